// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Reads the frequency ring buffer and feeds the tone generator. Entries are
//   popped one at a time. Each popped frequency and its index are presented as
//   a registered word with a one-cycle tone_valid strobe, and each is held for
//   a programmable dwell interval. Between pops the block serves single host
//   random-access reads of the ring. These reads use a valid/ready handshake
//   and are abandoned if the ring does not answer within TIMEOUT cycles.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   enable            : run sequencing (level)
//   dwell             : cycles each tone is held (0 behaves as 1), sampled at pop
//   ring_dout         : ring data word (pop data or random-read data)
//   ring_ready        : ring can be popped
//   ring_index        : index of ring_dout for pops
//   ring_rd_en        : pop strobe (combinational)
//   ring_rand_addr    : random-read address (registered)
//   ring_rand_en      : random-read request, high for the whole RAND visit
//   ring_rand_valid   : random-read data valid on ring_dout this cycle
//   tone_freq/index   : current tone word and its ring index
//   tone_valid        : one-cycle strobe when the tone registers update
//   req_addr/valid    : host random-read request
//   req_ready         : request accepted this cycle (combinational)
//   resp_data/valid   : random-read result with one-cycle strobe
//   resp_timeout      : one-cycle strobe when a random read is abandoned
module tone_sequencer #(
  parameter int DWELL_W = 16,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [13:0]        ring_dout,
  input  logic               ring_ready,
  input  logic [6:0]         ring_index,
  output logic               ring_rd_en,
  output logic [6:0]         ring_rand_addr,
  output logic               ring_rand_en,
  input  logic               ring_rand_valid,
  output logic [13:0]        tone_freq,
  output logic [6:0]         tone_index,
  output logic               tone_valid,
  input  logic [6:0]         req_addr,
  input  logic               req_valid,
  output logic               req_ready,
  output logic [13:0]        resp_data,
  output logic               resp_valid,
  output logic               resp_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DWELL, RAND} state_t;

  state_t             state_q, state_d, exit_state;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [13:0]        tone_freq_q, tone_freq_d;
  logic [6:0]         tone_index_q, tone_index_d;
  logic               tone_valid_q, tone_valid_d;
  logic [6:0]         rand_addr_q, rand_addr_d;
  logic               rand_en_q, rand_en_d;
  logic [13:0]        resp_data_q, resp_data_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_timeout_q, resp_timeout_d;

  // Dwell counter load value: max(d,1)-1, so the DWELL state lasts max(d,1) cycles.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  always_comb begin
    state_d        = state_q;
    dwell_cnt_d    = dwell_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    tone_freq_d    = tone_freq_q;
    tone_index_d   = tone_index_q;
    tone_valid_d   = 1'b0;
    rand_addr_d    = rand_addr_q;
    rand_en_d      = rand_en_q;
    resp_data_d    = resp_data_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = 1'b0;
    ring_rd_en     = 1'b0;
    exit_state     = enable ? FETCH : IDLE;
    // Host requests win over a pop in the same cycle, so the pop is only
    // considered when no request is being accepted.
    req_ready      = req_valid && (state_q == IDLE || state_q == FETCH);

    if (req_ready) begin
      state_d     = RAND;
      rand_addr_d = req_addr;
      rand_en_d   = 1'b1;
      tmo_cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_d = FETCH;
        end
        FETCH: begin
          ring_rd_en = ring_ready;
          if (ring_ready) begin
            tone_freq_d  = ring_dout;
            tone_index_d = ring_index;
            tone_valid_d = 1'b1;
            dwell_cnt_d  = dwell_load(dwell);
            state_d      = DWELL;
          end else if (!enable) begin
            state_d = IDLE;
          end
        end
        DWELL: begin
          if (dwell_cnt_q == '0) state_d = exit_state;
          else dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
        RAND: begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          // Dropping ring_rand_en on the exit edge keeps the ring from
          // seeing a second request for the same read.
          if (ring_rand_valid) begin
            resp_data_d  = ring_dout;
            resp_valid_d = 1'b1;
            rand_en_d    = 1'b0;
            state_d      = exit_state;
          end else if (tmo_cnt_q == TMO_LAST) begin
            resp_timeout_d = 1'b1;
            rand_en_d      = 1'b0;
            state_d        = exit_state;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dwell_cnt_q    <= '0;
      tmo_cnt_q      <= '0;
      tone_freq_q    <= '0;
      tone_index_q   <= '0;
      tone_valid_q   <= 1'b0;
      rand_addr_q    <= '0;
      rand_en_q      <= 1'b0;
      resp_data_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_cnt_q    <= dwell_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      tone_freq_q    <= tone_freq_d;
      tone_index_q   <= tone_index_d;
      tone_valid_q   <= tone_valid_d;
      rand_addr_q    <= rand_addr_d;
      rand_en_q      <= rand_en_d;
      resp_data_q    <= resp_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign tone_freq      = tone_freq_q;
  assign tone_index     = tone_index_q;
  assign tone_valid     = tone_valid_q;
  assign ring_rand_addr = rand_addr_q;
  assign ring_rand_en   = rand_en_q;
  assign resp_data      = resp_data_q;
  assign resp_valid     = resp_valid_q;
  assign resp_timeout   = resp_timeout_q;

endmodule
